// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage with single-entry buffer, redirect and halt
//
// Fetches one instruction word at a time from instruction memory into a single-entry
// buffer presented to decode. A new request is overlapped with draining the buffer,
// so a 0-wait memory with a always-ready decode stage sustains one instruction per cycle.
//
// Ports:
//   clk, rst_n              clock; synchronous active-low reset
//   imem_req, imem_addr     fetch request; held stable until imem_ack
//   imem_ack, imem_rdata    memory response; data valid in the ack cycle
//   inst, inst_pc           buffered instruction and its word address
//   inst_valid, inst_ready  handshake to decode
//   redirect, redirect_pc   taken branch from execute; flush and refetch
//   halted                  HALT delivered; fetch stopped until reset
//
// Optional feature: define IF_PREFETCH_BRANCH_EN to follow unconditional branches
// (imem_rdata[31:25] == 7'b1100000) at fetch time using the sign-extended offset.

module if_fetch #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_HOLD,
    S_DROP,
    S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic [ADDR_W-1:0] redir_q, redir_d;
  logic [31:0]       inst_q, inst_d;
  logic              inst_valid_q, inst_valid_d;
  logic              halted_q, halted_d;
  logic              halt_pend_q, halt_pend_d;
  logic              req_en_q;

  logic              xfer;
  logic              capture;
  logic              rdata_halt;
  logic [ADDR_W-1:0] next_pc;

  assign xfer       = inst_valid_q && inst_ready;
  assign rdata_halt = (imem_rdata[31:30] == 2'b11) && (imem_rdata[28:25] == 4'b1000);

  // A request is only raised when the buffer is empty or drains this cycle. Once
  // raised without an ack the buffer is necessarily empty afterwards, so the request
  // stays up until acked. req_en_q keeps the first cycle after reset request-free.
  always_comb begin
    imem_req = 1'b0;
    case (state_q)
      S_FETCH: imem_req = rst_n && req_en_q && (!inst_valid_q || inst_ready);
      S_DROP:  imem_req = rst_n;
      default: imem_req = 1'b0;
    endcase
  end

  assign capture   = imem_req && imem_ack;
  assign imem_addr = pc_q;

`ifdef IF_PREFETCH_BRANCH_EN
  logic [ADDR_W+15:0] br_off_sx;
  assign br_off_sx = {{ADDR_W{imem_rdata[15]}}, imem_rdata[15:0]};
  assign next_pc   = (imem_rdata[31:25] == 7'b1100000) ? (pc_q + br_off_sx[ADDR_W-1:0])
                                                       : (pc_q + ADDR_W'(1));
`else
  assign next_pc   = pc_q + ADDR_W'(1);
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_pc_d    = inst_pc_q;
    redir_d      = redir_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    halted_d     = halted_q;
    halt_pend_d  = halt_pend_q;

    case (state_q)
      S_FETCH: begin
        if (xfer) begin
          inst_valid_d = 1'b0;
        end
        if (redirect) begin
          inst_valid_d = 1'b0;
          if (imem_req && !imem_ack) begin
            // Outstanding request must complete before the new target is fetched.
            redir_d = redirect_pc;
            state_d = S_DROP;
          end else begin
            // No request, or the ack coincides: the response is simply not captured.
            pc_d = redirect_pc;
          end
        end else if (capture) begin
          inst_d       = imem_rdata;
          inst_pc_d    = pc_q;
          inst_valid_d = 1'b1;
          pc_d         = next_pc;
          if (rdata_halt) begin
            halt_pend_d = 1'b1;
            state_d     = S_HOLD;
          end
        end else if (inst_valid_q && !inst_ready) begin
          state_d = S_HOLD;
        end
      end

      S_HOLD: begin
        // A HALT already accepted by decode wins over a coincident redirect.
        if (xfer && halt_pend_q) begin
          inst_valid_d = 1'b0;
          halt_pend_d  = 1'b0;
          halted_d     = 1'b1;
          state_d      = S_HALT;
        end else if (redirect) begin
          inst_valid_d = 1'b0;
          halt_pend_d  = 1'b0;
          pc_d         = redirect_pc;
          state_d      = S_FETCH;
        end else if (xfer) begin
          inst_valid_d = 1'b0;
          state_d      = S_FETCH;
        end
      end

      S_DROP: begin
        if (imem_ack) begin
          pc_d    = redirect ? redirect_pc : redir_q;
          state_d = S_FETCH;
        end else if (redirect) begin
          redir_d = redirect_pc;
        end
      end

      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      inst_pc_q    <= '0;
      redir_q      <= '0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      halt_pend_q  <= 1'b0;
      req_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_pc_q    <= inst_pc_d;
      redir_q      <= redir_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      halted_q     <= halted_d;
      halt_pend_q  <= halt_pend_d;
      req_en_q     <= 1'b1;
    end
  end

  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = inst_valid_q;
  assign halted     = halted_q;

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter: ADDR_W, 16, instruction-memory word-address width.
REQ-002 Parameter: RESET_PC, 16'h0000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  ADDR_W  word address of the requested fetch.
REQ-007 imem_ack  input  1  memory response strobe; imem_rdata is valid in the same cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 inst  output  32  instruction presented to decode.
REQ-010 inst_pc  output  ADDR_W  address of inst.
REQ-011 inst_valid  output  1  inst/inst_pc are valid.
REQ-012 inst_ready  input  1  decode accepts inst this cycle.
REQ-013 redirect  input  1  taken branch from execute; flush and refetch.
REQ-014 redirect_pc  input  ADDR_W  branch target.
REQ-015 halted  output  1  HALT fetched; fetching stopped.

Function
REQ-016 States: FETCH, HOLD, DROP, HALT.
- FETCH: imem_req=1.
- HOLD: one instruction buffered, imem_req=0.
- DROP: waits out a stale request.
- HALT: idle.
REQ-017 imem_req and imem_addr SHALL hold stable from assertion until the cycle imem_ack=1.
REQ-018 FETCH with imem_ack=1 and no redirect SHALL capture imem_rdata into inst, the fetch address into inst_pc, and set inst_valid next cycle.
- If imem_ack=1 arrives in the same cycle as the request is raised, the result SHALL appear on inst_valid one cycle later (1-cycle latency).
REQ-019 A transfer occurs when inst_valid=1 and inst_ready=1.
- On transfer, PC SHALL advance by 1 and the block SHALL return to FETCH.
- Without transfer, the block SHALL stay in HOLD with inst/inst_pc/inst_valid unchanged.
REQ-020 In FETCH, imem_ack SHALL be captured only when the buffer is empty or being drained in that cycle; otherwise imem_req SHALL be 0 (single-entry buffer, never overwritten).
REQ-021 Redirect in HOLD or FETCH-without-outstanding-request SHALL:
- clear inst_valid the next cycle;
- load PC with redirect_pc;
- go to FETCH.
REQ-022 Redirect while a request is outstanding (imem_req=1, imem_ack=0) SHALL:
- latch redirect_pc;
- clear inst_valid;
- go to DROP, keeping imem_req/imem_addr stable.
- On imem_ack the response SHALL be discarded and the block SHALL go to FETCH at the latched target.
REQ-023 Redirect coincident with imem_ack SHALL discard the response and fetch redirect_pc next.
REQ-024 A second redirect while in DROP SHALL overwrite the latched target (last wins).
REQ-025 HALT detection: imem_rdata[31:30]=2'b11 and imem_rdata[28:25]=4'b1000.
- On a captured HALT, the HALT instruction SHALL still be delivered via inst_valid.
- After that transfer the block SHALL enter HALT: halted=1, imem_req=0, inst_valid=0.
- HALT SHALL be left only by reset; redirect in HALT SHALL be ignored.
REQ-026 PC arithmetic is modulo 2^ADDR_W: PC={ADDR_W{1}} SHALL advance to 0.

Reset
REQ-027 When rst_n=0 at a rising edge, the block SHALL set:
- state=FETCH, PC=RESET_PC;
- inst=0, inst_pc=0, inst_valid=0, halted=0;
- imem_req=0 during reset;
- latched redirect target cleared.
REQ-028 Reset mid-request SHALL abandon the outstanding request; any imem_ack in the first cycle after reset SHALL be ignored. The first request SHALL be issued in the second cycle after rst_n rises.

Configuration
REQ-029 Macro IF_PREFETCH_BRANCH_EN.
- Defined: a captured word with imem_rdata[31:25]=7'b1100000 (unconditional branch) SHALL set next PC = inst_pc + sign-extended imem_rdata[15:0] (mod 2^ADDR_W) instead of inst_pc+1. The branch is still delivered to decode.
- Undefined: PC always advances by 1 and only redirect changes flow.

Verification
REQ-030 Reset, imem_ack tied 1 (0-wait memory), inst_ready=1: inst_pc sequence 0,1,2,3 on consecutive cycles; first inst_valid 2 cycles after rst_n rises.
REQ-031 inst_ready=0 for 5 cycles with word 0x12345678 at addr 4: inst held stable, imem_req=0, no advance; on ready, next fetch addr=5.
REQ-032 imem_ack delayed 3 cycles, redirect to 0x0040 in wait cycle 1: imem_addr stable until ack, response dropped, next imem_addr=0x0040, no inst_valid for the stale word.
REQ-033 Word 0xD0000000 (HALT) at addr 7: delivered with inst_pc=7, then halted=1, imem_req=0 permanently; redirect ignored; reset clears it.
REQ-034 IF_PREFETCH_BRANCH_EN defined, word 0xC000FFFE at addr 0x0010: next imem_addr=0x000E. Undefined: next imem_addr=0x0011.
REQ-035 PC=0xFFFF, accepted: next imem_addr=0x0000.
